// File: rtl/decode_stage.sv
// decode_stage: splits instructions into Execute controls, reads a write-through register file,
// interlocks RAW hazards with a pending scoreboard and holds the result in the ID/EX register.
module decode_stage #(
  parameter int DATAW = 32,
  parameter int PCW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [31:0]      instr,
  input  logic [PCW-1:0]   PC_in,
  output logic             ready_out,
  input  logic             stall_in,
  input  logic             flush_in,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [DATAW-1:0] wb_data,
  output logic             valid_out,
  output logic             alu_op,
  output logic             branch_in,
  output logic             use_imm,
  output logic [1:0]       shift_dist,
  output logic [DATAW-1:0] a,
  output logic [DATAW-1:0] b,
  output logic [10:0]      imm,
  output logic [PCW-1:0]   PC_out,
  output logic [4:0]       rd_out,
  output logic             wr_en_out
);
  typedef struct packed {
    logic             valid;
    logic             alu_op;
    logic             branch;
    logic             use_imm;
    logic [1:0]       shift;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic [10:0]      imm;
    logic [PCW-1:0]   pc;
    logic [4:0]       rd;
    logic             wr;
  } idex_t;

  idex_t            r_idex, w_dec;
  logic [DATAW-1:0] r_rf [32];
  logic [31:0]      r_pend;
  logic [3:0]       w_op;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic [DATAW-1:0] w_a, w_b;
  logic             w_rd1, w_rd2, w_wr, w_hz, w_go;
  logic [31:0]      w_set, w_clr;

  assign w_op  = instr[31:28];
  assign w_rd  = instr[27:23];
  assign w_rs1 = instr[22:18];
  assign w_rs2 = instr[17:13];
  assign w_rd1 = w_op == 4'd1 || w_op == 4'd2 || w_op == 4'd4 || w_op == 4'd5;
  assign w_rd2 = w_op == 4'd1 || w_op == 4'd4 || w_op == 4'd5;
  assign w_wr  = (w_op == 4'd1 || w_op == 4'd2 || w_op == 4'd3) && w_rd != 5'd0;

  // Same-cycle writeback bypasses the array so dependents issue without a bubble
  assign w_a = w_rs1 == 5'd0 ? '0 : (wb_en && wb_rd == w_rs1) ? wb_data : r_rf[w_rs1];
  assign w_b = w_rs2 == 5'd0 ? '0 : (wb_en && wb_rd == w_rs2) ? wb_data : r_rf[w_rs2];

  assign w_hz = valid_in &&
    ((w_rd1 && w_rs1 != 5'd0 && r_pend[w_rs1] && !(wb_en && wb_rd == w_rs1)) ||
     (w_rd2 && w_rs2 != 5'd0 && r_pend[w_rs2] && !(wb_en && wb_rd == w_rs2)));

  assign ready_out = flush_in || (!stall_in && !w_hz);
  assign w_go      = valid_in && !flush_in && !stall_in && !w_hz;
  assign w_set     = (w_go && w_wr) ? (32'd1 << w_rd) : 32'd0;
  assign w_clr     = wb_en ? (32'd1 << wb_rd) : 32'd0;

  always_comb begin
    w_dec         = '0;
    w_dec.valid   = 1'b1;
    w_dec.alu_op  = w_op == 4'd2 || w_op == 4'd5;
    w_dec.branch  = w_op == 4'd4 || w_op == 4'd5;
    w_dec.use_imm = w_op == 4'd3;
    w_dec.shift   = (w_op == 4'd0 || w_op > 4'd5) ? 2'd0 : instr[12:11];
    w_dec.a       = w_rd1 ? w_a : '0;
    w_dec.b       = w_rd2 ? w_b : '0;
    w_dec.imm     = instr[10:0];
    w_dec.pc      = PC_in;
    w_dec.rd      = w_rd;
    w_dec.wr      = w_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idex <= '0;
    else if (flush_in) r_idex <= '0;
    else if (!stall_in) r_idex <= (w_hz || !valid_in) ? '0 : w_dec;
  end

  // Set wins over a same-register clear; bit 0 never tracks anything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else r_pend <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      r_rf[wb_rd] <= wb_data;
    end
  end

  assign valid_out  = r_idex.valid;
  assign alu_op     = r_idex.alu_op;
  assign branch_in  = r_idex.branch;
  assign use_imm    = r_idex.use_imm;
  assign shift_dist = r_idex.shift;
  assign a          = r_idex.a;
  assign b          = r_idex.b;
  assign imm        = r_idex.imm;
  assign PC_out     = r_idex.pc;
  assign rd_out     = r_idex.rd;
  assign wr_en_out  = r_idex.wr;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n, valid_in, stall_in, flush_in, wb_en;
  logic [31:0] instr, PC_in, wb_data;
  logic [4:0]  wb_rd;
  logic        ready_out, valid_out, alu_op, branch_in, use_imm, wr_en_out;
  logic [1:0]  shift_dist;
  logic [31:0] a, b, PC_out;
  logic [10:0] imm;
  logic [4:0]  rd_out;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATAW(32), .PCW(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .instr(instr), .PC_in(PC_in),
    .ready_out(ready_out), .stall_in(stall_in), .flush_in(flush_in),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_out(valid_out), .alu_op(alu_op), .branch_in(branch_in), .use_imm(use_imm),
    .shift_dist(shift_dist), .a(a), .b(b), .imm(imm), .PC_out(PC_out),
    .rd_out(rd_out), .wr_en_out(wr_en_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [1:0] sh, input logic [10:0] im);
    return {op, rd, s1, s2, sh, im};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    valid_in = 1'b1;
    instr    = ins;
    PC_in    = pc;
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; stall_in = 1'b0; flush_in = 1'b0; wb_en = 1'b0;
    instr = '0; PC_in = '0; wb_rd = '0; wb_data = '0;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_a", a, 0);
    check("rst_pc", PC_out, 0);
    check("rst_rdy", ready_out, 1);
    rst_n = 1'b1;
    tick;
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
    tick;
    wb_rd = 5'd2; wb_data = 32'd7;
    tick;
    wb_en = 1'b0;
    issue(enc(4'd1, 5'd3, 5'd1, 5'd2, 2'd0, 11'd0), 32'h100);
    #1 check("add_rdy", ready_out, 1);
    tick;
    check("add_valid", valid_out, 1);
    check("add_a", a, 5);
    check("add_b", b, 7);
    check("add_alu", alu_op, 0);
    check("add_wr", wr_en_out, 1);
    check("add_rd", rd_out, 3);
    check("add_pc", PC_out, 32'h100);
    issue(enc(4'd3, 5'd4, 5'd0, 5'd0, 2'd2, 11'h0AB), 32'h104);
    tick;
    check("ldi_use_imm", use_imm, 1);
    check("ldi_imm", imm, 11'h0AB);
    check("ldi_shift", shift_dist, 2);
    check("ldi_rd", rd_out, 4);
    check("ldi_a", a, 0);
    issue(enc(4'd2, 5'd7, 5'd4, 5'd0, 2'd0, 11'd0), 32'h108);
    #1 check("inc_haz_rdy", ready_out, 0);
    tick;
    check("inc_bubble1", valid_out, 0);
    check("inc_haz_rdy2", ready_out, 0);
    tick;
    check("inc_bubble2", valid_out, 0);
    wb_en = 1'b1; wb_rd = 5'd4; wb_data = 32'd9;
    #1 check("inc_wt_rdy", ready_out, 1);
    tick;
    check("inc_valid", valid_out, 1);
    check("inc_a", a, 9);
    check("inc_alu", alu_op, 1);
    check("inc_rd", rd_out, 7);
    check("inc_pc", PC_out, 32'h108);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234;
    issue(enc(4'd5, 5'd0, 5'd6, 5'd1, 2'd0, 11'd0), 32'h10C);
    tick;
    wb_en = 1'b0;
    check("bgt_a", a, 32'h1234);
    check("bgt_b", b, 5);
    check("bgt_branch", branch_in, 1);
    check("bgt_alu", alu_op, 1);
    check("bgt_wr", wr_en_out, 0);
    stall_in = 1'b1;
    issue(enc(4'd3, 5'd8, 5'd0, 5'd0, 2'd1, 11'h155), 32'h200);
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_rdy", ready_out, 0);
      tick;
      check("stall_hold_a", a, 32'h1234);
      check("stall_hold_br", branch_in, 1);
      check("stall_hold_pc", PC_out, 32'h10C);
    end
    stall_in = 1'b0;
    #1 check("unstall_rdy", ready_out, 1);
    tick;
    check("unstall_imm", imm, 11'h155);
    check("unstall_use_imm", use_imm, 1);
    check("unstall_pc", PC_out, 32'h200);
    flush_in = 1'b1; stall_in = 1'b1;
    issue(enc(4'd1, 5'd5, 5'd1, 5'd2, 2'd0, 11'd0), 32'h300);
    #1 check("flush_rdy", ready_out, 1);
    tick;
    check("flush_valid", valid_out, 0);
    check("flush_a", a, 0);
    flush_in = 1'b0; stall_in = 1'b0;
    issue(enc(4'd2, 5'd9, 5'd5, 5'd0, 2'd0, 11'd0), 32'h304);
    #1 check("flush_nopend_rdy", ready_out, 1);
    tick;
    check("flush_nopend_valid", valid_out, 1);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
    issue(enc(4'd1, 5'd0, 5'd0, 5'd0, 2'd0, 11'd0), 32'h400);
    tick;
    wb_en = 1'b0;
    check("r0_a", a, 0);
    check("r0_b", b, 0);
    check("r0_wr", wr_en_out, 0);
    check("r0_valid", valid_out, 1);
    issue(enc(4'd1, 5'd10, 5'd0, 5'd1, 2'd0, 11'd0), 32'h404);
    tick;
    check("r0_read_a", a, 0);
    check("r0_read_b", b, 5);
    issue(enc(4'd7, 5'd3, 5'd1, 5'd2, 2'd3, 11'd1), 32'h408);
    tick;
    check("nop_valid", valid_out, 1);
    check("nop_ctrl", {alu_op, branch_in, use_imm, wr_en_out, shift_dist}, 0);
    check("nop_a", a, 0);
    valid_in = 1'b0;
    tick;
    check("idle_valid", valid_out, 0);
    issue(enc(4'd3, 5'd12, 5'd0, 5'd0, 2'd0, 11'd3), 32'h500);
    tick;
    check("pre_rst_valid", valid_out, 1);
    stall_in = 1'b1;
    rst_n = 1'b0;
    #1 check("midstall_rst_valid", valid_out, 0);
    check("midstall_rst_imm", imm, 0);
    tick;
    rst_n = 1'b1;
    stall_in = 1'b0;
    issue(enc(4'd2, 5'd11, 5'd12, 5'd0, 2'd0, 11'd0), 32'h600);
    #1 check("post_rst_rdy", ready_out, 1);
    tick;
    check("post_rst_valid", valid_out, 1);
    check("post_rst_rf_a", a, 0);
    valid_in = 1'b0;
    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
